uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- Parametrised successor to the fixed 8N1 serial receiver.
- Configurable data width, parity mode and stop-bit count.
- Rejects false start bits, flags framing and parity errors, and holds one received frame in a valid/ready output register with overrun reporting.
- Sits between the serial pin and any byte consumer (sink, FIFO, command decoder), paired with the existing transmitter.

Parameters:
CLOCKS_PER_BIT, 4, clock cycles per serial bit; legal range 3..255
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
_clock  in  1  single clock; all state updates on its rising edge
_reset  in  1  synchronous, active-low reset (0 = reset)
_in  in  1  serial line, idle high; asynchronous to _clock
_out  out  DATA_BITS  received data, LSB = first bit received
_out_valid  out  1  _out and the error flags are valid
_out_ready  in  1  consumer accepts the frame when _out_valid && _out_ready
_frame_err  out  1  a stop bit sampled 0; qualified by _out_valid
_parity_err  out  1  parity mismatch; qualified by _out_valid; always 0 when PARITY=0
_overrun  out  1  one-cycle pulse: a completed frame was dropped
_busy  out  1  state != IDLE

Behaviour:
- Reset (_reset==0 on a clock edge): state IDLE, delay 0, shift 0, _out 0, _out_valid 0, both error flags 0, _overrun 0, synchroniser flops 1.
- Reset applied mid-frame aborts the frame with no output.
- _in passes through a 2-flop synchroniser; rx_s is its output, 2 cycles of latency.
- delay counter: width $clog2(CLOCKS_PER_BIT). MID = CLOCKS_PER_BIT/2 (integer division).
- Sample point: delay==MID. Bit boundary: delay==CLOCKS_PER_BIT-1, where delay wraps to 0 and the state/bit counter advances.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s==0, go to START with delay=0.
  - START: at the sample point, if rx_s==1 (glitch), return to IDLE next cycle with no output. Otherwise continue to DATA at the bit boundary.
  - DATA: sample into shift, LSB first, shift right from MSB. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: sample the parity bit. Error if XOR(data, parity bit) != (PARITY==2).
  - STOP: sample each stop bit; any 0 sets frame_err. Commit the frame at the sample point of the final stop bit and go directly to IDLE, without waiting out the rest of that bit. This lets a back-to-back start bit be caught.
- Commit: registered. _out, _frame_err and _parity_err load and _out_valid rises the cycle after the final stop-bit sample.
  - Frames with errors are still delivered, with their flags set.
- Handshake:
  - _out_valid holds, with _out and flags stable, until accepted (_out_valid && _out_ready). It drops on the next cycle unless a commit occurs in the same cycle.
  - Commit in the same cycle as acceptance: the new frame loads and _out_valid stays 1.
  - Commit while _out_valid && !_out_ready: the new frame is discarded, the held frame is unchanged, and _overrun pulses for 1 cycle.
- _out_ready is ignored while _out_valid==0.
- Bit counter width: $clog2(DATA_BITS+1).

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s at delay MID-1, MID and MID+1. The value is resolved at MID+1, and all decisions (glitch reject, parity, stop) move to MID+1. Commit moves one cycle later.
- Undefined: single sample at MID as described above.
- Either way, CLOCKS_PER_BIT >= 3 is required.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum {PAR_NONE, PAR_EVEN, PAR_ODD}
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - function for parity computation
- The existing tx can later adopt parity_t.
- One sub-module: uart_sync, a 2-flop synchroniser with reset value 1.

Test Plan:
1. CLOCKS_PER_BIT=4, 8N1, _out_ready=1; send 0x55 then 0xA3 back-to-back. Expect _out 0x55 then 0xA3, each valid 1 cycle, no flags.
2. PARITY=1, DATA_BITS=7; send 0x41 with parity bit 0, then with parity bit 1. Expect the first with _parity_err=0, the second with _parity_err=1.
3. STOP_BITS=2; send 0x3C with the second stop bit driven 0. Expect _out=0x3C and _frame_err=1.
4. Drive a 1-cycle low pulse on _in while idle. Expect _busy to assert, return to IDLE, and _out_valid to stay 0.
5. _out_ready=0; send 0x11 then 0x22. Expect _out to hold 0x11 and _overrun to pulse once. Raise _out_ready: expect 0x11 accepted, _out_valid drops.
6. Assert _reset=0 mid-DATA of 0x7E, release, then send 0x81. Expect only 0x81 delivered. Repeat with UART_RX_MAJORITY_EN defined and a 1-cycle glitch at MID: data still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and parity helper
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Parity bit a well-formed frame carries for the given data; data is zero-extended to 9 bits
   function automatic logic parity_expected(input logic [8:0] data, input parity_t mode);
      return (mode == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser for the idle-high serial line
module uart_sync (
   input  logic _clock,
   input  logic _reset,
   input  logic _in,
   output logic _out
);

   logic meta;

   // Two flops in series; both reset to the idle line level
   always_ff @(posedge _clock) begin
      if (!_reset) begin
         meta <= 1'b1;
         _out <= 1'b1;
      end else begin
         meta <= _in;
         _out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - configurable serial frame receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx_frame #(
   parameter int CLOCKS_PER_BIT = 4,
   parameter int DATA_BITS      = 8,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1
) (
   input  logic                 _clock,
   input  logic                 _reset,
   input  logic                 _in,
   output logic [DATA_BITS-1:0] _out,
   output logic                 _out_valid,
   input  logic                 _out_ready,
   output logic                 _frame_err,
   output logic                 _parity_err,
   output logic                 _overrun,
   output logic                 _busy
);

   import uart_pkg::*;

   localparam int DW  = $clog2(CLOCKS_PER_BIT);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam int MID = CLOCKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int DECIDE = MID + 1;
`else
   localparam int DECIDE = MID;
`endif

   localparam logic [DW-1:0] D_DECIDE  = DW'(DECIDE);
   localparam logic [DW-1:0] D_LAST    = DW'(CLOCKS_PER_BIT - 1);
   localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam parity_t       PAR_MODE  = parity_t'(PARITY);

   logic                 rx_s;
   logic                 bit_val;
   rx_state_t            state;
   logic [DW-1:0]        delay;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 fe_acc;
   logic                 pe_acc;

   uart_sync u_sync (
      ._clock (_clock),
      ._reset (_reset),
      ._in    (_in),
      ._out   (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   localparam logic [DW-1:0] D_EARLY = DW'(MID - 1);
   localparam logic [DW-1:0] D_MID   = DW'(MID);

   logic s_early;
   logic s_mid;

   // Hold the two samples preceding the deciding one so the vote resolves at MID+1
   always_ff @(posedge _clock) begin
      if (!_reset) begin
         s_early <= 1'b1;
         s_mid   <= 1'b1;
      end else begin
         if (delay == D_EARLY) s_early <= rx_s;
         if (delay == D_MID)   s_mid   <= rx_s;
      end
   end

   assign bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
   assign bit_val = rx_s;
`endif

   assign _busy = (state != IDLE);

   // Frame state machine plus the single-entry valid/ready output register
   always_ff @(posedge _clock) begin
      if (!_reset) begin
         state       <= IDLE;
         delay       <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         shift       <= '0;
         fe_acc      <= 1'b0;
         pe_acc      <= 1'b0;
         _out        <= '0;
         _out_valid  <= 1'b0;
         _frame_err  <= 1'b0;
         _parity_err <= 1'b0;
         _overrun    <= 1'b0;
      end else begin
         _overrun <= 1'b0;
         if (_out_valid && _out_ready) _out_valid <= 1'b0;
         delay <= (delay == D_LAST) ? '0 : delay + 1'b1;

         case (state)
            IDLE: begin
               delay <= '0;
               if (!rx_s) begin
                  state    <= START;
                  bit_cnt  <= '0;
                  stop_cnt <= 1'b0;
                  fe_acc   <= 1'b0;
                  pe_acc   <= 1'b0;
               end
            end
            START: begin
               if (delay == D_DECIDE && bit_val) begin
                  // Line went back high before mid-bit: not a real start bit
                  state <= IDLE;
                  delay <= '0;
               end else if (delay == D_LAST) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (delay == D_DECIDE) shift <= {bit_val, shift[DATA_BITS-1:1]};
               if (delay == D_LAST) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == B_LAST) begin
                     bit_cnt <= '0;
                     state   <= (PAR_MODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
                  end
               end
            end
            uart_pkg::PARITY: begin
               if (delay == D_DECIDE) pe_acc <= (bit_val != parity_expected(9'(shift), PAR_MODE));
               if (delay == D_LAST) state <= STOP;
            end
            STOP: begin
               if (delay == D_DECIDE) begin
                  if (stop_cnt == STOP_LAST) begin
                     // Commit on the last stop sample and return to IDLE early to catch a back-to-back start
                     state <= IDLE;
                     delay <= '0;
                     if (!_out_valid || _out_ready) begin
                        _out        <= shift;
                        _frame_err  <= fe_acc | ~bit_val;
                        _parity_err <= pe_acc;
                        _out_valid  <= 1'b1;
                     end else begin
                        _overrun <= 1'b1;
                     end
                  end else if (!bit_val) begin
                     fe_acc <= 1'b1;
                  end
               end
               if (delay == D_LAST) stop_cnt <= 1'b1;
            end
            default: begin
               state <= IDLE;
               delay <= '0;
            end
         endcase
      end
   end

endmodule
